// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending machine credit/vend/change controller with registered outputs.
// Optional inactivity refund in CREDIT is enabled by defining VEND_TIMEOUT_EN.
module vend_ctrl #(
  parameter int MAX_CREDIT     = 500,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       coin_valid,
  input  logic [1:0] coin_val,
  input  logic       sel_valid,
  input  logic [2:0] item_sel,
  input  logic [8:0] item_cost,
  input  logic       cancel,
  output logic [8:0] credit,
  output logic       dispense,
  output logic [2:0] dispense_item,
  output logic       change_valid,
  output logic [8:0] change_amt,
  output logic       coin_reject,
  output logic       insufficient,
  output logic       busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CREDIT,
    S_VEND,
    S_CHANGE
  } state_t;

  localparam logic [9:0] MAX_CREDIT_W = 10'(MAX_CREDIT);

  state_t     state, state_nx;
  logic [8:0] credit_nx;
  logic [8:0] change_amt_nx;
  logic [2:0] item_nx;
  logic       dispense_nx;
  logic       change_valid_nx;
  logic       coin_reject_nx;
  logic       insufficient_nx;
  logic       busy_nx;

  logic [9:0] coin_cents;
  logic [9:0] coin_sum;
  logic       coin_fits;
  logic       can_afford;

`ifdef VEND_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idle_cnt, idle_cnt_nx;
  logic          timeout_hit;

  assign timeout_hit = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    coin_cents = 10'd5;
    case (coin_val)
      2'b00:   coin_cents = 10'd5;
      2'b01:   coin_cents = 10'd10;
      2'b10:   coin_cents = 10'd25;
      default: coin_cents = 10'd100;
    endcase
  end

  // Widened sum so an overflowing coin cannot wrap below the limit.
  assign coin_sum   = {1'b0, credit} + coin_cents;
  assign coin_fits  = (coin_sum <= MAX_CREDIT_W);
  assign can_afford = (credit >= item_cost);

  always_comb begin
    state_nx        = state;
    credit_nx       = credit;
    change_amt_nx   = change_amt;
    item_nx         = dispense_item;
    dispense_nx     = 1'b0;
    change_valid_nx = 1'b0;
    coin_reject_nx  = 1'b0;
    insufficient_nx = 1'b0;
`ifdef VEND_TIMEOUT_EN
    idle_cnt_nx     = '0;
`endif
    case (state)
      S_IDLE, S_CREDIT: begin
        if (cancel) begin
          coin_reject_nx = coin_valid;
          if (state == S_CREDIT) begin
            state_nx        = S_CHANGE;
            change_valid_nx = 1'b1;
            change_amt_nx   = credit;
          end
        end else if (sel_valid) begin
          coin_reject_nx = coin_valid;
          if (can_afford) begin
            state_nx    = S_VEND;
            item_nx     = item_sel;
            credit_nx   = credit - item_cost;
            dispense_nx = 1'b1;
          end else begin
            insufficient_nx = 1'b1;
          end
        end else if (coin_valid) begin
          if (coin_fits) begin
            credit_nx = coin_sum[8:0];
            state_nx  = S_CREDIT;
          end else begin
            coin_reject_nx = 1'b1;
          end
`ifdef VEND_TIMEOUT_EN
        end else if (state == S_CREDIT) begin
          if (timeout_hit) begin
            state_nx        = S_CHANGE;
            change_valid_nx = 1'b1;
            change_amt_nx   = credit;
          end else begin
            idle_cnt_nx = idle_cnt + 1'b1;
          end
`endif
        end
      end
      S_VEND: begin
        coin_reject_nx = coin_valid;
        if (credit != 9'd0) begin
          state_nx        = S_CHANGE;
          change_valid_nx = 1'b1;
          change_amt_nx   = credit;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: begin
        coin_reject_nx = coin_valid;
        credit_nx      = 9'd0;
        state_nx       = S_IDLE;
      end
    endcase
    busy_nx = (state_nx == S_VEND) || (state_nx == S_CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      credit        <= 9'd0;
      change_amt    <= 9'd0;
      dispense_item <= 3'd0;
      dispense      <= 1'b0;
      change_valid  <= 1'b0;
      coin_reject   <= 1'b0;
      insufficient  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nx;
      credit        <= credit_nx;
      change_amt    <= change_amt_nx;
      dispense_item <= item_nx;
      dispense      <= dispense_nx;
      change_valid  <= change_valid_nx;
      coin_reject   <= coin_reject_nx;
      insufficient  <= insufficient_nx;
      busy          <= busy_nx;
    end
  end

`ifdef VEND_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_nx;
    end
  end
`endif

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - directed and randomized checks of vend_ctrl against a credit-ledger model.
module tb_vend_ctrl;
  localparam int MAXC = 500;
  localparam int TMO  = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin_valid;
  logic [1:0] coin_val;
  logic       sel_valid;
  logic [2:0] item_sel;
  logic [8:0] item_cost;
  logic       cancel;
  logic [8:0] credit;
  logic       dispense;
  logic [2:0] dispense_item;
  logic       change_valid;
  logic [8:0] change_amt;
  logic       coin_reject;
  logic       insufficient;
  logic       busy;

  always #5 clk = ~clk;

  vend_ctrl #(.MAX_CREDIT(MAXC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .coin_valid(coin_valid), .coin_val(coin_val),
    .sel_valid(sel_valid), .item_sel(item_sel), .item_cost(item_cost), .cancel(cancel),
    .credit(credit), .dispense(dispense), .dispense_item(dispense_item),
    .change_valid(change_valid), .change_amt(change_amt), .coin_reject(coin_reject),
    .insufficient(insufficient), .busy(busy)
  );

  int tests = 0;
  int fails = 0;

  int cost_tab [8] = '{125, 50, 85, 150, 0, 5, 200, 35};

  // Ledger model: phase 0 = accepting, 1 = dispensing this cycle, 2 = returning change.
  int m_credit, m_phase, m_item, m_chg, m_idle;
  bit e_disp, e_chg, e_rej, e_ins;

  function automatic int cents(input logic [1:0] v);
    case (v)
      2'b00:   return 5;
      2'b01:   return 10;
      2'b10:   return 25;
      default: return 100;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [9:0] obs, input int exp);
    tests++;
    assert (obs === 10'(exp)) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0; m_phase = 0; m_item = 0; m_chg = 0; m_idle = 0;
    e_disp = 0; e_chg = 0; e_rej = 0; e_ins = 0;
  endtask

  task automatic refund();
    m_phase = 2; e_chg = 1; m_chg = m_credit;
  endtask

  task automatic model_step(input bit cv, input logic [1:0] cval, input bit sv,
                            input int item, input bit can);
    e_disp = 0; e_chg = 0; e_rej = 0; e_ins = 0;
    if (m_phase == 1) begin
      e_rej = cv;
      if (m_credit > 0) refund(); else m_phase = 0;
    end else if (m_phase == 2) begin
      e_rej = cv; m_credit = 0; m_phase = 0;
    end else begin
      if (can) begin
        e_rej = cv;
        if (m_credit > 0) refund();
      end else if (sv) begin
        e_rej = cv;
        if (m_credit >= cost_tab[item]) begin
          m_credit -= cost_tab[item]; m_item = item; e_disp = 1; m_phase = 1;
        end else begin
          e_ins = 1;
        end
      end else if (cv) begin
        if (m_credit + cents(cval) <= MAXC) m_credit += cents(cval);
        else e_rej = 1;
`ifdef VEND_TIMEOUT_EN
      end else if (m_credit > 0) begin
        m_idle++;
        if (m_idle == TMO) refund();
`endif
      end
    end
    if (m_phase != 0 || cv || sv || can || m_credit == 0) m_idle = 0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ":credit"}, {1'b0, credit}, m_credit);
    chk({where, ":dispense"}, {9'd0, dispense}, int'(e_disp));
    chk({where, ":dispense_item"}, {7'd0, dispense_item}, m_item);
    chk({where, ":change_valid"}, {9'd0, change_valid}, int'(e_chg));
    chk({where, ":change_amt"}, {1'b0, change_amt}, m_chg);
    chk({where, ":coin_reject"}, {9'd0, coin_reject}, int'(e_rej));
    chk({where, ":insufficient"}, {9'd0, insufficient}, int'(e_ins));
    chk({where, ":busy"}, {9'd0, busy}, int'(m_phase != 0));
  endtask

  task automatic step(input string where, input bit cv, input logic [1:0] cval,
                      input bit sv, input int item, input bit can);
    @(negedge clk);
    coin_valid = cv; coin_val = cval; sel_valid = sv;
    item_sel = 3'(item); item_cost = 9'(cost_tab[item]); cancel = can;
    @(posedge clk);
    model_step(cv, cval, sv, item, can);
    #1;
    check_outputs(where);
    coin_valid = 1'b0; sel_valid = 1'b0; cancel = 1'b0;
  endtask

  task automatic idle(input string where, input int n);
    for (int i = 0; i < n; i++) step(where, 0, 2'b00, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; coin_valid = 1'b0; coin_val = 2'b00; sel_valid = 1'b0;
    item_sel = 3'd0; item_cost = 9'd0; cancel = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Exact payment: 100 + 25 for a 125 item, no change.
    step("exact_c100", 1, 2'b11, 0, 0, 0);
    step("exact_c25", 1, 2'b10, 0, 0, 0);
    step("exact_sel", 0, 2'b00, 1, 0, 0);
    step("exact_n2", 0, 2'b00, 0, 0, 0);
    step("exact_n3", 0, 2'b00, 0, 0, 0);

    // Overpayment: 200 for an 85 item returns 115.
    step("chg_c1", 1, 2'b11, 0, 0, 0);
    step("chg_c2", 1, 2'b11, 0, 0, 0);
    step("chg_sel", 0, 2'b00, 1, 2, 0);
    step("chg_n2", 0, 2'b00, 0, 0, 0);
    step("chg_n3", 0, 2'b00, 0, 0, 0);
    chk("chg_amt_115", {1'b0, change_amt}, 115);

    // Insufficient credit then cancel.
    step("ins_c1", 1, 2'b10, 0, 0, 0);
    step("ins_c2", 1, 2'b10, 0, 0, 0);
    step("ins_sel", 0, 2'b00, 1, 3, 0);
    step("ins_cancel", 0, 2'b00, 0, 0, 1);
    step("ins_n2", 0, 2'b00, 0, 0, 0);

    // Selection in IDLE: refused unless free.
    step("idle_sel", 0, 2'b00, 1, 1, 0);
    step("idle_free", 0, 2'b00, 1, 4, 0);
    step("idle_free_n2", 0, 2'b00, 0, 0, 0);

    // Credit ceiling, then coin+cancel together.
    for (int i = 0; i < 5; i++) step("max_fill", 1, 2'b11, 0, 0, 0);
    step("max_over", 1, 2'b00, 0, 0, 0);
    step("max_cancel", 1, 2'b00, 0, 0, 1);
    step("max_n2", 1, 2'b01, 0, 0, 0);
    chk("max_refund_500", {1'b0, change_amt}, 500);

    // Coin with selection in same cycle: coin rejected, vend proceeds.
    step("pri_c", 1, 2'b11, 0, 0, 0);
    step("pri_sel_coin", 1, 2'b11, 1, 7, 0);
    step("pri_vend_coin", 1, 2'b00, 1, 0, 1);
    step("pri_n3", 0, 2'b00, 0, 0, 0);

    // Reset asserted during the VEND cycle.
    step("rst_c", 1, 2'b11, 0, 0, 0);
    step("rst_sel", 0, 2'b00, 1, 2, 0);
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_outputs("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    idle("rst_after", 3);

    // Held credit with no activity: refunded only when the timeout is built in.
    step("tmo_c", 1, 2'b10, 0, 0, 0);
    idle("tmo_idle", TMO + 3);

    do_reset();
    for (int i = 0; i < 400; i++) begin
      bit         cv, sv, can;
      logic [1:0] cval;
      int         item;
      cv   = ($urandom_range(0, 99) < 45);
      sv   = ($urandom_range(0, 99) < 15);
      can  = ($urandom_range(0, 99) < 5);
      cval = 2'($urandom_range(0, 3));
      item = $urandom_range(0, 7);
      step("rand", cv, cval, sv, item, can);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
